// File: rtl/ias_core_param.sv
// ias_core_param: parametrised IAS-style accumulator machine (AC, MQ, PC, IR)
// wrapped around an internal word memory with a preload port. A multi-cycle
// FETCH/DECODE/EXEC/WB sequencer runs the program from address 0 after
// 'start' until HALT or an illegal opcode.
// Optional feature: define IAS_MUL_EN to add the shift-add MUL instruction.
module ias_core_param #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int OP_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic              busy,
   output logic              halted,
   output logic              err,
   output logic              ovf,
   output logic [DATA_W-1:0] ac_out,
   output logic [DATA_W-1:0] mq_out,
   output logic [ADDR_W-1:0] pc_out
);

   localparam logic [OP_W-1:0] OP_HALT  = OP_W'('h00);
   localparam logic [OP_W-1:0] OP_LOAD  = OP_W'('h01);
   localparam logic [OP_W-1:0] OP_LOADN = OP_W'('h02);
   localparam logic [OP_W-1:0] OP_ADD   = OP_W'('h05);
   localparam logic [OP_W-1:0] OP_SUB   = OP_W'('h06);
   localparam logic [OP_W-1:0] OP_LDMQM = OP_W'('h09);
   localparam logic [OP_W-1:0] OP_LDMQ  = OP_W'('h0A);
   localparam logic [OP_W-1:0] OP_STOR  = OP_W'('h21);
   localparam logic [OP_W-1:0] OP_JUMP  = OP_W'('h0D);
   localparam logic [OP_W-1:0] OP_JUMPP = OP_W'('h0F);
`ifdef IAS_MUL_EN
   localparam logic [OP_W-1:0] OP_MUL   = OP_W'('h0B);
   localparam int              CNT_W    = $clog2(DATA_W) + 1;
`endif

`ifdef IAS_MUL_EN
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_MUL} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
`endif

   state_t            state_q, state_d;
   logic [DATA_W-1:0] ac_q, ac_d, mq_q, mq_d, ir_q, ir_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              err_q, err_d, ovf_q, ovf_d;
   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;
   logic [ADDR_W-1:0] memAddr, memWaddr;
   logic [DATA_W-1:0] memWdata;
   logic              memWe;
   logic              busyInt;
   logic [OP_W-1:0]   irOp, fetchOp;
   logic [ADDR_W-1:0] irAddr;
   logic [DATA_W-1:0] sum, diff;
   logic              addOvf, subOvf;
`ifdef IAS_MUL_EN
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W:0]   mulAcc, mulOperand, mulSum;
   logic              mulLast;
`endif

   assign irOp    = ir_q[OP_W+ADDR_W-1:ADDR_W];
   assign irAddr  = ir_q[ADDR_W-1:0];
   assign fetchOp = rdata_q[OP_W+ADDR_W-1:ADDR_W];

   assign sum    = ac_q + rdata_q;
   assign diff   = ac_q - rdata_q;
   assign addOvf = (ac_q[DATA_W-1] == rdata_q[DATA_W-1]) && (sum[DATA_W-1] != ac_q[DATA_W-1]);
   assign subOvf = (ac_q[DATA_W-1] != rdata_q[DATA_W-1]) && (diff[DATA_W-1] != ac_q[DATA_W-1]);

`ifdef IAS_MUL_EN
   // One signed shift-add step: add the multiplicand for set multiplier bits,
   // but subtract it for the multiplier sign bit on the final iteration.
   assign mulLast    = (cnt_q == CNT_W'(DATA_W - 1));
   assign mulAcc     = {ac_q[DATA_W-1], ac_q};
   assign mulOperand = {rdata_q[DATA_W-1], rdata_q};
   always_comb begin
      mulSum = mulAcc;
      if (mq_q[0]) mulSum = mulLast ? (mulAcc - mulOperand) : (mulAcc + mulOperand);
   end
`endif

   // Read address: the operand address during EXEC (and MUL), otherwise the PC.
   always_comb begin
      memAddr = pc_q;
      if (state_q == S_EXEC) memAddr = irAddr;
`ifdef IAS_MUL_EN
      if (state_q == S_MUL) memAddr = irAddr;
`endif
   end

   // Write port is shared between STOR and the idle-time preload strobe.
   always_comb begin
      memWe    = 1'b0;
      memWaddr = prog_addr;
      memWdata = prog_data;
      if (state_q == S_EXEC && irOp == OP_STOR) begin
         memWe    = 1'b1;
         memWaddr = irAddr;
         memWdata = ac_q;
      end else if (prog_we && !busyInt) begin
         memWe = 1'b1;
      end
   end

   // Word memory with synchronous write and registered read data.
   always_ff @(posedge clk) begin
      if (memWe) mem[memWaddr] <= memWdata;
      rdata_q <= mem[memAddr];
   end

   // Sequencer state register; reset aborts any instruction in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Sequencer next state; HALT is recognised directly from fetched data.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_HALT: if (start) state_d = S_FETCH;
         S_FETCH:        state_d = S_DECODE;
         S_DECODE:       state_d = (fetchOp == OP_HALT) ? S_HALT : S_EXEC;
         S_EXEC: begin
            case (irOp)
               OP_LOAD, OP_LOADN, OP_ADD, OP_SUB, OP_LDMQM: state_d = S_WB;
               OP_LDMQ, OP_STOR, OP_JUMP, OP_JUMPP:         state_d = S_FETCH;
`ifdef IAS_MUL_EN
               OP_MUL:                                      state_d = S_MUL;
`endif
               default:                                     state_d = S_HALT;
            endcase
         end
         S_WB:           state_d = S_FETCH;
`ifdef IAS_MUL_EN
         S_MUL:          if (mulLast) state_d = S_FETCH;
`endif
         default:        state_d = S_IDLE;
      endcase
   end

   // Status outputs decoded from the sequencer state.
   always_comb begin
      busyInt = !(state_q == S_IDLE || state_q == S_HALT);
      halted  = (state_q == S_HALT);
   end

   assign busy   = busyInt;
   assign err    = err_q;
   assign ovf    = ovf_q;
   assign ac_out = ac_q;
   assign mq_out = mq_q;
   assign pc_out = pc_q;

   // Architectural register updates for each sequencer phase.
   always_comb begin
      ac_d  = ac_q;
      mq_d  = mq_q;
      pc_d  = pc_q;
      ir_d  = ir_q;
      err_d = err_q;
      ovf_d = ovf_q;
`ifdef IAS_MUL_EN
      cnt_d = cnt_q;
`endif
      case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               pc_d  = '0;
               ac_d  = '0;
               mq_d  = '0;
               err_d = 1'b0;
               ovf_d = 1'b0;
            end
         end
         S_DECODE: begin
            ir_d = rdata_q;
            pc_d = pc_q + ADDR_W'(1);
         end
         S_EXEC: begin
            case (irOp)
               OP_LDMQ:  ac_d = mq_q;
               OP_JUMP:  pc_d = irAddr;
               OP_JUMPP: if (!ac_q[DATA_W-1]) pc_d = irAddr;
               OP_LOAD, OP_LOADN, OP_ADD, OP_SUB, OP_LDMQM, OP_STOR: ;
`ifdef IAS_MUL_EN
               OP_MUL: begin
                  ac_d  = '0;
                  cnt_d = '0;
               end
`endif
               default:  err_d = 1'b1;
            endcase
         end
         S_WB: begin
            case (irOp)
               OP_LOAD:  ac_d = rdata_q;
               OP_LOADN: ac_d = -rdata_q;
               OP_ADD: begin
                  ac_d  = sum;
                  ovf_d = ovf_q | addOvf;
               end
               OP_SUB: begin
                  ac_d  = diff;
                  ovf_d = ovf_q | subOvf;
               end
               OP_LDMQM: mq_d = rdata_q;
               default: ;
            endcase
         end
`ifdef IAS_MUL_EN
         S_MUL: begin
            ac_d  = mulSum[DATA_W:1];
            mq_d  = {mulSum[0], mq_q[DATA_W-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
         end
`endif
         default: ;
      endcase
   end

   // Architectural registers, cleared by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ac_q  <= '0;
         mq_q  <= '0;
         pc_q  <= '0;
         ir_q  <= '0;
         err_q <= 1'b0;
         ovf_q <= 1'b0;
`ifdef IAS_MUL_EN
         cnt_q <= '0;
`endif
      end else begin
         ac_q  <= ac_d;
         mq_q  <= mq_d;
         pc_q  <= pc_d;
         ir_q  <= ir_d;
         err_q <= err_d;
         ovf_q <= ovf_d;
`ifdef IAS_MUL_EN
         cnt_q <= cnt_d;
`endif
      end
   end

endmodule
